// File: rtl/udma_l2_port_arbiter.sv
// Round-robin arbiter sharing one uDMA L2 port among N_REQ requesters; in-order responses routed back via an ID FIFO.
// Latency: zero-cycle combinational arbitration and response routing; state updates on the handshake or response edge.
// Backpressure: L2_req_o is held low while MAX_OUTSTANDING transfers are in flight (no full bypass); optional UDMA_L2_ARB_LOCK_EN enables grant locking.
module udma_l2_port_arbiter #(
  parameter int N_REQ           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rst_i,
  input  logic [N_REQ-1:0]                     req_i,
  output logic [N_REQ-1:0]                     gnt_o,
  input  logic [N_REQ-1:0]                     wen_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]   be_i,
  input  logic [N_REQ-1:0]                     lock_i,
  output logic [N_REQ-1:0]                     rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 L2_req_o,
  input  logic                                 L2_gnt_i,
  output logic                                 L2_wen_o,
  output logic [ADDR_WIDTH-1:0]                L2_addr_o,
  output logic [DATA_WIDTH-1:0]                L2_wdata_o,
  output logic [DATA_WIDTH/8-1:0]              L2_be_o,
  input  logic                                 L2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                L2_rdata_i,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   rr_next;
  logic [IDW:0]     cand;
  logic             found;
  logic [N_REQ-1:0] eligible;

  logic [IDW-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             err_q;

`ifdef UDMA_L2_ARB_LOCK_EN
  logic             lock_vld;
  logic [IDW-1:0]   lock_id;

  // While locked only the owner competes, even if it is not requesting right now
  always_comb begin
    eligible = req_i;
    if (lock_vld) eligible = req_i & (N_REQ'(1) << lock_id);
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;

  // Pure round-robin: every requester competes
  always_comb begin
    eligible = req_i;
  end
`endif

  // Pick the first eligible requester at or after rr_ptr, wrapping at N_REQ-1
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!found && eligible[cand[IDW-1:0]]) begin
        sel   = cand[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  assign rr_next    = (sel == IDW'(N_REQ - 1)) ? '0 : sel + 1'b1;
  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  assign L2_req_o   = found && !fifo_full && !sys_rst_i;
  assign push       = L2_req_o && L2_gnt_i;
  assign pop        = L2_rvalid_i && !fifo_empty && !sys_rst_i;

  assign L2_wen_o   = wen_i[sel];
  assign L2_addr_o  = addr_i[sel];
  assign L2_wdata_o = wdata_i[sel];
  assign L2_be_o    = be_i[sel];

  assign gnt_o      = push ? (N_REQ'(1) << sel) : '0;
  assign rvalid_o   = pop ? (N_REQ'(1) << fifo_mem[rd_ptr]) : '0;
  assign rdata_o    = L2_rdata_i;
  assign busy_o     = !fifo_empty && !sys_rst_i;
  assign err_o      = err_q;

  // Arbiter pointer, ID FIFO bookkeeping, sticky error and lock ownership
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
`ifdef UDMA_L2_ARB_LOCK_EN
      lock_vld <= 1'b0;
      lock_id  <= '0;
`endif
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sel;
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
`ifdef UDMA_L2_ARB_LOCK_EN
        if (lock_i[sel]) begin
          lock_vld <= 1'b1;
          lock_id  <= sel;
        end else begin
          lock_vld <= 1'b0;
          rr_ptr   <= rr_next;
        end
`else
        rr_ptr <= rr_next;
`endif
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      // A response with nothing in flight means the memory side lost sync
      if (L2_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udma_l2_port_arbiter.sv
// Randomized and directed bench for udma_l2_port_arbiter against a queue-based model.
// Inputs change on the falling edge; outputs are compared 1 ns later, model state advances on the rising edge.
// Build with or without UDMA_L2_ARB_LOCK_EN; the model follows the same macro.
module tb_udma_l2_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int M  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [N-1:0]         wen;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0][BW-1:0] be;
  logic [N-1:0]         lock;
  logic [N-1:0]         rvalid;
  logic [DW-1:0]        rdata;
  logic                 l2_req;
  logic                 l2_gnt;
  logic                 l2_wen;
  logic [AW-1:0]        l2_addr;
  logic [DW-1:0]        l2_wdata;
  logic [BW-1:0]        l2_be;
  logic                 l2_rvalid;
  logic [DW-1:0]        l2_rdata;
  logic                 busy;
  logic                 err;

  always #5 clk = ~clk;

  udma_l2_port_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(M)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .req_i(req), .gnt_o(gnt), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .lock_i(lock), .rvalid_o(rvalid), .rdata_o(rdata),
    .L2_req_o(l2_req), .L2_gnt_i(l2_gnt), .L2_wen_o(l2_wen), .L2_addr_o(l2_addr),
    .L2_wdata_o(l2_wdata), .L2_be_o(l2_be), .L2_rvalid_i(l2_rvalid),
    .L2_rdata_i(l2_rdata), .busy_o(busy), .err_o(err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: next requester to favour, in-flight IDs in grant order, error, lock owner (-1 = none)
  int m_rr    = 0;
  int m_q[$];
  bit m_err   = 1'b0;
  int m_owner = -1;
  bit m_hs;
  bit m_pop;
  int m_sel;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k] && r < 0) r = k;
    return r;
  endfunction

  // Compute what the outputs must be this cycle and compare them
  task automatic eval();
    int          s;
    int          r;
    bit          e_req;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    #1;
    s = -1;
    for (int k = 0; k < N; k++) begin
      r = (m_rr + k) % N;
      if (s < 0 && req[r] && (m_owner < 0 || m_owner == r)) s = r;
    end
    e_req = (s >= 0) && (m_q.size() < M) && !rst;
    m_hs  = e_req && l2_gnt;
    m_sel = s;
    m_pop = l2_rvalid && (m_q.size() > 0) && !rst;
    e_gnt = m_hs ? (N'(1) << s) : '0;
    e_rv  = m_pop ? (N'(1) << m_q[0]) : '0;
    chk("l2_req", 64'(l2_req), 64'(e_req));
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("rvalid", 64'(rvalid), 64'(e_rv));
    chk("busy", 64'(busy), 64'((m_q.size() > 0) && !rst));
    chk("err", 64'(err), 64'(m_err));
    if (e_req) begin
      chk("l2_addr", 64'(l2_addr), 64'(addr[s]));
      chk("l2_wdata", 64'(l2_wdata), 64'(wdata[s]));
      chk("l2_be", 64'(l2_be), 64'(be[s]));
      chk("l2_wen", 64'(l2_wen), 64'(wen[s]));
    end
    if (m_pop) chk("rdata", 64'(rdata), 64'(l2_rdata));
  endtask

  // Advance the model across the rising edge, then return at the next falling edge
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_rr = 0;
      m_q.delete();
      m_err = 1'b0;
      m_owner = -1;
    end else begin
      if (l2_rvalid && m_q.size() == 0) m_err = 1'b1;
      if (m_pop) void'(m_q.pop_front());
      if (m_hs) begin
        m_q.push_back(m_sel);
`ifdef UDMA_L2_ARB_LOCK_EN
        if (lock[m_sel]) m_owner = m_sel;
        else begin
          m_owner = -1;
          m_rr = (m_sel + 1) % N;
        end
`else
        m_rr = (m_sel + 1) % N;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b0; lock = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    eval(); adv();
    eval(); adv();
    rst = 1'b0;
  endtask

  int g[6];
  int fair_exp[6];
  int lk[5];
  int lk_exp[5];
  int bp_rv[4];
  int bp_exp[4];

  initial begin
    rst = 1'b1;
    idle_inputs();
    wen = '0; addr = '0; wdata = '0; be = '0; l2_rdata = '0;
    for (int k = 0; k < N; k++) begin
      addr[k]  = 32'h1C00_0000 + 32'(k * 16);
      wdata[k] = 32'hD000_0000 + 32'(k);
      be[k]    = 4'hF;
    end
    @(negedge clk);

    // Reset state, with requests and a response present while reset is held
    req = 4'b1111; l2_gnt = 1'b1; l2_rvalid = 1'b1;
    eval();
    chk("rst_l2_req", 64'(l2_req), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    adv();
    do_reset();
    eval();
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    adv();

    // Single requester
    req = 4'b0001; l2_gnt = 1'b1; addr[0] = 32'h1C00_0100;
    eval();
    chk("single_addr", 64'(l2_addr), 64'h1C00_0100);
    chk("single_gnt", 64'(gnt), 64'b0001);
    adv();
    idle_inputs();
    eval(); adv();
    l2_rvalid = 1'b1; l2_rdata = 32'hCAFE_F00D;
    eval();
    chk("single_rvalid", 64'(rvalid), 64'b0001);
    chk("single_rdata", 64'(rdata), 64'hCAFE_F00D);
    adv();

    // Fairness with all requesters active
    do_reset();
    fair_exp = '{0, 1, 2, 3, 0, 1};
    req = 4'b1111; l2_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      l2_rvalid = (i > 0);
      l2_rdata = $urandom;
      eval();
      g[i] = idx_of(gnt);
      adv();
    end
    for (int i = 0; i < 6; i++) chk($sformatf("fair_grant%0d", i), 64'(g[i]), 64'(fair_exp[i]));
    idle_inputs(); l2_rvalid = 1'b1;
    eval(); adv();

    // Backpressure: fill the FIFO, no bypass on the freeing cycle, then in-order routing
    do_reset();
    req = 4'b1111; l2_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin eval(); adv(); end
    eval();
    chk("bp_full_req", 64'(l2_req), 64'd0);
    chk("bp_full_busy", 64'(busy), 64'd1);
    adv();
    l2_rvalid = 1'b1;
    eval();
    chk("bp_nobypass_req", 64'(l2_req), 64'd0);
    chk("bp_pop_rvalid", 64'(rvalid), 64'b0001);
    adv();
    l2_rvalid = 1'b0;
    eval();
    chk("bp_reopen_req", 64'(l2_req), 64'd1);
    adv();
    bp_exp = '{1, 2, 3, 0};
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin eval(); bp_rv[i] = idx_of(rvalid); adv(); end
    for (int i = 0; i < 4; i++) chk($sformatf("bp_order%0d", i), 64'(bp_rv[i]), 64'(bp_exp[i]));
    l2_rvalid = 1'b0;
    eval();
    chk("bp_drained_busy", 64'(busy), 64'd0);
    adv();

    // Grant and earlier response in the same cycle
    do_reset();
    req = 4'b0010; l2_gnt = 1'b1;
    eval(); adv();
    req = 4'b0100; l2_rvalid = 1'b1;
    eval();
    chk("il_gnt", 64'(gnt), 64'b0100);
    chk("il_rvalid", 64'(rvalid), 64'b0010);
    adv();
    req = '0;
    eval();
    chk("il_next_rvalid", 64'(rvalid), 64'b0100);
    adv();
    l2_rvalid = 1'b0;
    eval();
    chk("il_busy", 64'(busy), 64'd0);
    adv();

    // Spurious response
    do_reset();
    l2_rvalid = 1'b1;
    eval();
    chk("spur_rvalid", 64'(rvalid), 64'd0);
    adv();
    l2_rvalid = 1'b0;
    eval();
    chk("spur_err", 64'(err), 64'd1);
    adv();
    for (int i = 0; i < 3; i++) begin eval(); adv(); end
    eval();
    chk("spur_err_sticky", 64'(err), 64'd1);
    adv();
    do_reset();
    eval();
    chk("spur_err_cleared", 64'(err), 64'd0);
    adv();

    // Lock: three locked transfers by requester 0, then an unlocking one
`ifdef UDMA_L2_ARB_LOCK_EN
    lk_exp = '{0, 0, 0, 0, 1};
`else
    lk_exp = '{0, 1, 0, 1, 0};
`endif
    do_reset();
    req = 4'b0011; l2_gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lock = (i < 3) ? 4'b0001 : 4'b0000;
      l2_rvalid = (i > 0);
      eval();
      lk[i] = idx_of(gnt);
      adv();
    end
    for (int i = 0; i < 5; i++) chk($sformatf("lock_grant%0d", i), 64'(lk[i]), 64'(lk_exp[i]));
    idle_inputs(); l2_rvalid = 1'b1;
    eval(); adv();
    do_reset();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req       = N'($urandom);
      l2_gnt    = ($urandom_range(0, 3) != 0);
      l2_rvalid = ($urandom_range(0, 2) != 0);
      l2_rdata  = $urandom;
      lock      = N'($urandom & $urandom);
      for (int k = 0; k < N; k++) begin
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        be[k]    = BW'($urandom);
        wen[k]   = 1'($urandom);
      end
      eval();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
